prach_tdm_sched: RTL and testbench

PRACH_TDM_SCHED -- requirements
Module: prach_tdm_sched

---
 rtl/prach_tdm_sched_if.sv | 30 +++
 rtl/prach_tdm_sched.sv | 136 +++++++++++++
 tb/tb_prach_tdm_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prach_tdm_sched_if.sv
// Control, configuration and slot-stream signals of the PRACH TDM scheduler.
// The master drives the controls; the slave is the scheduler.
interface prach_tdm_sched_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic              sample_tick;
  logic              cfg_we;
  logic [NUM_CH-1:0] cfg_mask;
  logic              ovf_clr;
  logic [7:0]        dout_chn;
  logic              dout_dv;
  logic              dout_sync;
  logic              busy;
  logic              cfg_pend;
  logic              overrun;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output start, stop, sample_tick, cfg_we, cfg_mask, ovf_clr,
    input  dout_chn, dout_dv, dout_sync, busy, cfg_pend, overrun, frame_cnt
  );

  modport slave (
    input  start, stop, sample_tick, cfg_we, cfg_mask, ovf_clr,
    output dout_chn, dout_dv, dout_sync, busy, cfg_pend, overrun, frame_cnt
  );
endinterface

// File: rtl/prach_tdm_sched.sv
// PRACH TDM slot scheduler: each accepted sample_tick emits one frame of
// NUM_CH consecutive channel slots, gated by a double-buffered channel mask.
module prach_tdm_sched #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  prach_tdm_sched_if.slave bus
);
  localparam int         IDX_W = $clog2(NUM_CH);
  localparam logic [7:0] LAST  = 8'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SLOT} state_t;

  state_t            state;
  logic [7:0]        chn;
  logic              dv;
  logic              sync;
  logic              busy_q;
  logic              cfg_pend_q;
  logic              overrun_q;
  logic              stop_pend;
  logic              first_frame;
  logic [NUM_CH-1:0] active_mask;
  logic [NUM_CH-1:0] shadow_mask;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic              last_slot;
  logic              stop_eff;
  logic              accept;
  logic              drop;
  logic [NUM_CH-1:0] next_mask;
  logic [7:0]        chn_inc;

  // A stop seen in the same cycle as the last slot counts as pending.
  assign last_slot = (state == SLOT) && (chn == LAST);
  assign stop_eff  = stop_pend | bus.stop;
  assign accept    = bus.sample_tick &&
                     (((state == ARMED) && !bus.stop) || (last_slot && !stop_eff));
  assign drop      = bus.sample_tick && (state == SLOT) && !accept;
  assign next_mask = bus.cfg_we ? bus.cfg_mask : shadow_mask;
  assign chn_inc   = chn + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      chn         <= '0;
      dv          <= 1'b0;
      sync        <= 1'b0;
      busy_q      <= 1'b0;
      cfg_pend_q  <= 1'b0;
      overrun_q   <= 1'b0;
      stop_pend   <= 1'b0;
      first_frame <= 1'b0;
      active_mask <= '1;
      shadow_mask <= '1;
      frame_cnt_q <= '0;
    end else begin
      if (bus.cfg_we)
        shadow_mask <= bus.cfg_mask;

      if (accept) begin
        active_mask <= next_mask;
        cfg_pend_q  <= 1'b0;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end else if (bus.cfg_we) begin
        cfg_pend_q  <= 1'b1;
      end

      if (drop)
        overrun_q <= 1'b1;
      else if (bus.ovf_clr)
        overrun_q <= 1'b0;

      // Sync marks frames whose mask differs from the previous frame's context.
      if (accept) begin
        state       <= SLOT;
        chn         <= '0;
        dv          <= next_mask[0];
        sync        <= first_frame | cfg_pend_q | bus.cfg_we;
        busy_q      <= 1'b1;
        first_frame <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            stop_pend <= 1'b0;
            if (bus.start && !bus.stop) begin
              state       <= ARMED;
              busy_q      <= 1'b1;
              first_frame <= 1'b1;
            end
          end
          ARMED: begin
            if (bus.stop) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          SLOT: begin
            if (last_slot) begin
              chn       <= '0;
              dv        <= 1'b0;
              sync      <= 1'b0;
              stop_pend <= 1'b0;
              if (stop_eff) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state  <= ARMED;
              end
            end else begin
              chn  <= chn_inc;
              dv   <= active_mask[chn_inc[IDX_W-1:0]];
              sync <= 1'b0;
              if (bus.stop)
                stop_pend <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout_chn  = chn;
  assign bus.dout_dv   = dv;
  assign bus.dout_sync = sync;
  assign bus.busy      = busy_q;
  assign bus.cfg_pend  = cfg_pend_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_prach_tdm_sched.sv
// Bench for prach_tdm_sched: a frame-queue reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_prach_tdm_sched;
  localparam int NUM_CH = 8;
  // Frame counter narrowed so the wrap can be exercised in a short run.
  localparam int CNT_W  = 12;
  localparam int MOD    = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prach_tdm_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  prach_tdm_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int chn;
    bit dv;
    bit sync;
  } slot_t;

  // Reference model: a frame is a queue of slots pushed at acceptance time.
  slot_t       upcoming[$];
  slot_t       cur;
  bit          in_frame;
  bit          m_on;
  bit          m_stop_seen;
  bit          m_first;
  bit          m_pend;
  bit          m_ovf;
  logic [7:0]  m_shadow;
  int          m_cnt;

  task automatic model_reset();
    upcoming.delete();
    cur         = '{0, 1'b0, 1'b0};
    in_frame    = 1'b0;
    m_on        = 1'b0;
    m_stop_seen = 1'b0;
    m_first     = 1'b0;
    m_pend      = 1'b0;
    m_ovf       = 1'b0;
    m_shadow    = '1;
    m_cnt       = 0;
  endtask

  always @(posedge clk) begin
    bit         at_last, stop_now, accept, drop, sync;
    logic [7:0] mask;
    if (!rst_n) begin
      model_reset();
    end else begin
      at_last  = in_frame && (upcoming.size() == 0);
      stop_now = bus.stop || m_stop_seen;
      accept   = bus.sample_tick && m_on &&
                 ((!in_frame && !bus.stop) || (at_last && !stop_now));
      drop     = bus.sample_tick && in_frame && !accept;
      mask     = bus.cfg_we ? bus.cfg_mask : m_shadow;
      if (accept) begin
        sync = m_first || m_pend || bus.cfg_we;
        upcoming.delete();
        for (int k = 0; k < NUM_CH; k++)
          upcoming.push_back('{k, mask[k], (k == 0) && sync});
        cur      = upcoming.pop_front();
        in_frame = 1'b1;
        m_first  = 1'b0;
        m_pend   = 1'b0;
        m_cnt    = (m_cnt + 1) % MOD;
      end else begin
        if (bus.cfg_we) m_pend = 1'b1;
        if (in_frame) begin
          if (at_last) begin
            in_frame = 1'b0;
            if (stop_now) begin
              m_on        = 1'b0;
              m_stop_seen = 1'b0;
            end
          end else begin
            cur = upcoming.pop_front();
            if (bus.stop) m_stop_seen = 1'b1;
          end
        end else if (m_on) begin
          if (bus.stop) m_on = 1'b0;
        end else if (bus.start && !bus.stop) begin
          m_on    = 1'b1;
          m_first = 1'b1;
        end
      end
      if (bus.cfg_we) m_shadow = bus.cfg_mask;
      if (drop) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("model chn",   32'(bus.dout_chn),  32'(in_frame ? cur.chn : 0));
      check_output("model dv",    32'(bus.dout_dv),   32'(in_frame ? cur.dv : 1'b0));
      check_output("model sync",  32'(bus.dout_sync), 32'(in_frame ? cur.sync : 1'b0));
      check_output("model busy",  32'(bus.busy),      32'(m_on));
      check_output("model pend",  32'(bus.cfg_pend),  32'(m_pend));
      check_output("model ovf",   32'(bus.overrun),   32'(m_ovf));
      check_output("model fcnt",  32'(bus.frame_cnt), 32'(m_cnt));
    end
  end

  // One clock cycle with the given inputs; returns on the following negedge.
  task automatic apply_stimulus(input logic tick, input logic st, input logic sp,
                                input logic we, input logic [7:0] mask,
                                input logic oc);
    bus.sample_tick = tick;
    bus.start       = st;
    bus.stop        = sp;
    bus.cfg_we      = we;
    bus.cfg_mask    = mask;
    bus.ovf_clr     = oc;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_mask    = 8'h00;
    bus.ovf_clr     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic tick();
    apply_stimulus(1, 0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_mask    = 8'h00;
    bus.ovf_clr     = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check_output("reset chn",  32'(bus.dout_chn),  0);
    check_output("reset busy", 32'(bus.busy),      0);
    check_output("reset fcnt", 32'(bus.frame_cnt), 0);
    rst_n = 1'b1;
    idle(1);

    // Corner cases in IDLE
    tick();
    check_output("idle tick ovf", 32'(bus.overrun), 0);
    apply_stimulus(0, 1, 1, 0, 8'h00, 0);
    check_output("start+stop busy", 32'(bus.busy), 0);

    // Basic frame
    apply_stimulus(0, 1, 0, 0, 8'h00, 0);
    check_output("armed busy", 32'(bus.busy), 1);
    idle(2);
    tick();
    check_output("basic slot0 chn",  32'(bus.dout_chn),  0);
    check_output("basic slot0 sync", 32'(bus.dout_sync), 1);
    check_output("basic slot0 dv",   32'(bus.dout_dv),   1);
    idle(7);
    check_output("basic slot7 chn",  32'(bus.dout_chn),  7);
    check_output("basic slot7 sync", 32'(bus.dout_sync), 0);
    idle(1);
    check_output("basic end chn",  32'(bus.dout_chn),  0);
    check_output("basic end dv",   32'(bus.dout_dv),   0);
    check_output("basic end fcnt", 32'(bus.frame_cnt), 1);
    check_output("basic end busy", 32'(bus.busy),      1);

    // Back-to-back and overrun
    tick();
    idle(7);
    tick();
    check_output("b2b chn",  32'(bus.dout_chn),  0);
    check_output("b2b ovf",  32'(bus.overrun),   0);
    check_output("b2b fcnt", 32'(bus.frame_cnt), 3);
    idle(3);
    tick();
    check_output("drop ovf", 32'(bus.overrun),  1);
    check_output("drop chn", 32'(bus.dout_chn), 4);
    check_output("drop fcnt", 32'(bus.frame_cnt), 3);
    idle(4);
    apply_stimulus(0, 0, 0, 0, 8'h00, 1);
    check_output("ovf_clr", 32'(bus.overrun), 0);

    // Mask update written mid-frame
    tick();
    check_output("nomask sync", 32'(bus.dout_sync), 0);
    idle(1);
    apply_stimulus(0, 0, 0, 1, 8'h0F, 0);
    check_output("mask pend", 32'(bus.cfg_pend), 1);
    check_output("mask old dv", 32'(bus.dout_dv), 1);
    idle(6);
    tick();
    check_output("mask sync", 32'(bus.dout_sync), 1);
    check_output("mask pend clr", 32'(bus.cfg_pend), 0);
    idle(4);
    check_output("mask slot4 dv", 32'(bus.dout_dv), 0);
    idle(4);

    // Mask written together with the accepted tick
    apply_stimulus(1, 0, 0, 1, 8'hF0, 0);
    check_output("coinc dv0",  32'(bus.dout_dv),   0);
    check_output("coinc sync", 32'(bus.dout_sync), 1);
    check_output("coinc pend", 32'(bus.cfg_pend),  0);
    idle(8);
    apply_stimulus(0, 0, 0, 1, 8'hFF, 0);

    // Stop mid-frame, then a tick on the last slot
    tick();
    idle(2);
    apply_stimulus(0, 0, 1, 0, 8'h00, 0);
    check_output("stop slot3", 32'(bus.dout_chn), 3);
    idle(4);
    check_output("stop slot7", 32'(bus.dout_chn), 7);
    tick();
    check_output("stop busy", 32'(bus.busy),    0);
    check_output("stop ovf",  32'(bus.overrun), 1);
    apply_stimulus(0, 0, 0, 0, 8'h00, 1);

    // Reset in the middle of a frame
    apply_stimulus(0, 1, 0, 0, 8'h00, 0);
    tick();
    idle(5);
    check_output("pre-rst chn", 32'(bus.dout_chn), 5);
    rst_n = 1'b0;
    idle(1);
    check_output("rst chn",  32'(bus.dout_chn),  0);
    check_output("rst dv",   32'(bus.dout_dv),   0);
    check_output("rst busy", 32'(bus.busy),      0);
    check_output("rst fcnt", 32'(bus.frame_cnt), 0);
    rst_n = 1'b1;
    idle(1);

    // Stop wins over a simultaneous tick in ARMED
    apply_stimulus(0, 1, 0, 0, 8'h00, 0);
    apply_stimulus(1, 0, 1, 0, 8'h00, 0);
    check_output("armed stop busy", 32'(bus.busy),    0);
    check_output("armed stop ovf",  32'(bus.overrun), 0);

    // Frame counter wrap with continuous back-to-back frames
    apply_stimulus(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < MOD; i++) begin
      tick();
      if (i == MOD - 2)
        check_output("fcnt max", 32'(bus.frame_cnt), 32'(MOD - 1));
      idle(7);
    end
    check_output("fcnt wrap", 32'(bus.frame_cnt), 0);
    check_output("wrap ovf",  32'(bus.overrun),   0);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
